regfile_dump_reader: RTL
========================

// Module: regfile_dump_reader
// PURPOSE
//  Sequential reader for the 32x32 register file read port: sweeps ctrl_readReg over an
//  inclusive register range, captures each word, and streams it out on a valid/ready
//  handshake. Consumers are the debug/VGA overlay and the UART dumper. Owns one read port
//  (A or B, muxed in by the top level while the CPU is halted or the port is free).
// PARAMETERS
//  DATA_WIDTH  32  width of a register word
//  ADDR_WIDTH  5   register index width (2**ADDR_WIDTH registers)
//  SKIP_R0     0   1: never emit r0; any index 0 inside the range is stepped over
// PORTS
//  clock         in   1           system clock, rising edge
//  ctrl_reset    in   1           asynchronous reset, active-low
//  start         in   1           request a sweep; sampled only in IDLE
//  first_reg     in   ADDR_WIDTH  first index of the sweep, sampled with start
//  last_reg      in   ADDR_WIDTH  last index of the sweep (inclusive), sampled with start
//  ctrl_readReg  out  ADDR_WIDTH  index driven to the register file read port
//  data_readReg  in   DATA_WIDTH  combinational read data from the register file
//  out_valid     out  1           out_data/out_index/out_last hold a word
//  out_ready     in   1           consumer accepts the word when out_valid & out_ready
//  out_data      out  DATA_WIDTH  captured register word
//  out_index     out  ADDR_WIDTH  index out_data came from
//  out_last      out  1           word is the final one of the sweep
//  busy          out  1           high in every state except IDLE
//  done          out  1           one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset (ctrl_reset=0, async): state IDLE; ctrl_readReg=0, out_valid=0, out_data=0,
//   out_index=0, out_last=0, busy=0, done=0. Reset mid-sweep abandons it; no done pulse.
//  FSM IDLE -> FETCH -> SEND -> (FETCH | DONE) -> IDLE; all outputs registered.
//   IDLE:  start=1 latches first/last_reg; cur=first_reg (advanced past 0 if SKIP_R0).
//          If SKIP_R0 and the range holds only r0 -> DONE directly; else -> FETCH.
//   FETCH: ctrl_readReg=cur for exactly one cycle; at its end capture data_readReg into
//          out_data, cur into out_index, out_last=(cur==last) -> SEND.
//   SEND:  out_valid=1; out_data/out_index/out_last stable until accepted. On
//          out_valid&out_ready: if out_last -> DONE, else cur=next(cur) -> FETCH.
//          out_valid drops in the cycle after acceptance (one bubble per word).
//   DONE:  done=1 for one cycle, busy=1 -> IDLE.
//  next(i) = (i+1) mod 2**ADDR_WIDTH, repeated once more if result is 0 and SKIP_R0.
//  Wrap-around: first_reg > last_reg sweeps first..31, 0..last (33-first+last words).
//  first_reg == last_reg: single word, out_last=1 on it.
//  start while busy: ignored, not queued. first/last_reg changes mid-sweep: ignored.
//  ctrl_readReg holds its last value outside FETCH (no spurious reads matter; port is
//   read-only).
//  Snapshot is per-word, not atomic: each word reflects the register at its FETCH cycle;
//   a write landing on the same edge as capture is not seen (regfile updates on edge).
//  Latency: start sampled at edge N -> FETCH in N+1 -> out_valid at N+2. With out_ready
//   tied high, throughput is one word per 2 cycles; a full 32-word sweep = 64+2 cycles.
// TESTING
//  1. Preload r1..r31 = 0x1000_0000+i; start, first=0,last=31, ready=1 -> 32 words,
//     index 0..31, data 0 then 0x1000_0001.., out_last only on 31, done 1 cycle later.
//  2. first=29,last=2 -> indices 29,30,31,0,1,2 in order; out_last on index 2 only.
//  3. SKIP_R0=1, first=31,last=1 -> indices 31,1; first=0,last=0 -> no words, done pulse.
//  4. out_ready low 5 cycles while valid -> out_data/index/last unchanged, no loss or dup;
//     random ready backpressure over full sweep -> scoreboard matches preloaded values.
//  5. start pulsed repeatedly mid-sweep -> ignored; busy stays high; single done.
//  6. ctrl_reset low mid-SEND -> out_valid/busy drop immediately, no done; new start after
//     release performs a clean full sweep.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Sweeps a register-file read port over an inclusive index range and streams each
// captured word out on a valid/ready handshake, one FETCH + one SEND cycle per word.
module regfile_dump_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          SKIP_R0    = 1'b0
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    output logic [ADDR_WIDTH-1:0] ctrl_readReg,
    input  logic [DATA_WIDTH-1:0] data_readReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  valid_q, valid_d;
    logic                  olast_q, olast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] first_eff;
    logic [ADDR_WIDTH-1:0] last_eff;
    logic [ADDR_WIDTH-1:0] cur_next;
    logic                  only_r0;

    // With r0 skipped, a range ending on 0 really ends on the top index.
    always_comb begin
        first_eff = (SKIP_R0 && (first_reg == '0)) ? ADDR_WIDTH'(1) : first_reg;
        last_eff  = (SKIP_R0 && (last_reg == '0)) ? '1 : last_reg;
        only_r0   = SKIP_R0 && (first_reg == '0) && (last_reg == '0);
        cur_next  = cur_q + ADDR_WIDTH'(1);
        if (SKIP_R0 && (cur_next == '0)) begin
            cur_next = ADDR_WIDTH'(1);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        rd_idx_d = rd_idx_q;
        data_d   = data_q;
        index_d  = index_q;
        valid_d  = valid_q;
        olast_d  = olast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d  = first_eff;
                    last_d = last_eff;
                    busy_d = 1'b1;
                    if (only_r0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rd_idx_d = first_eff;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                data_d  = data_readReg;
                index_d = cur_q;
                olast_d = (cur_q == last_q);
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (olast_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d    = cur_next;
                        rd_idx_d = cur_next;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            last_q   <= '0;
            rd_idx_q <= '0;
            data_q   <= '0;
            index_q  <= '0;
            valid_q  <= 1'b0;
            olast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            rd_idx_q <= rd_idx_d;
            data_q   <= data_d;
            index_q  <= index_d;
            valid_q  <= valid_d;
            olast_q  <= olast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ctrl_readReg = rd_idx_q;
    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_index    = index_q;
    assign out_last     = olast_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
